multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multi-cycle sequencer for the register-file/ALU datapath. It owns the PC and fetches 32-bit RV32I-format instructions over a req/ack port. It decodes a small subset (ADD, SUB, ADDI, LW, SW, BEQ, JAL, JALR) and drives the datapath control bus (RS1/RS2/RD, IMM, ALUControl, ALUSrc, MemtoReg, RegWrite, link, pclink) one state at a time. It sits between instruction memory and the datapath; the data-memory handshake is sequenced here.

Parameters:
NBITS, 8, datapath/PC word width
NREGS, 32, register count; register index width is $clog2(NREGS)
WIDTH_ALUF, 4, ALUControl width
PC_RESET, 0, PC value loaded on reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instr_req  out  1  fetch request
instr_addr  out  NBITS  fetch address (= PC)
instr_ack  in  1  instruction valid this cycle
instr_rdata  in  32  fetched instruction
RS1, RS2, RD  out  $clog2(NREGS)  register indices to datapath
IMM  out  NBITS  signed immediate, sign-extended then truncated to NBITS
ALUControl  out  WIDTH_ALUF  ALU operation: 'b0000 = add, 'b1000 = sub
ALUSrc  out  1  1 = SrcB from IMM
MemtoReg  out  1  1 = write-back from ReadData
RegWrite  out  1  register-file write strobe, one cycle only
link  out  1  write pclink into RD
pclink  out  NBITS  PC+4 of the current instruction
Zero  in  1  ALU result == 0 (from datapath)
PCReg  in  NBITS  RS1 value, used as JALR target base
mem_req  out  1  data-memory request
mem_we  out  1  1 = store, 0 = load; valid with mem_req
mem_ack  in  1  data-memory completion
halted  out  1  sticky: illegal opcode trapped

Behaviour:
- Reset (reset = 0, async): PC = PC_RESET; IR = 0; state = FETCH. All strobes are 0: instr_req, RegWrite, link, mem_req, mem_we, halted. RS1/RS2/RD/IMM/ALUControl/ALUSrc/MemtoReg/pclink = 0.
- Control outputs are decoded from IR and state (registered IR, combinational decode). They are stable through every state after DECODE.
- States and transitions:
  - FETCH: instr_req = 1, instr_addr = PC. On instr_ack, IR <= instr_rdata and go to DECODE. instr_req stays high until ack, with no timeout.
  - DECODE: RS1/RS2/RD/IMM valid. Illegal opcode or funct goes to TRAP; otherwise go to EXEC.
  - EXEC: ALU settles. ADD/SUB/ADDI go to WB. LW/SW go to MEM. BEQ: if Zero, PC <= PC + IMM_B, else PC <= PC + 4; then go to FETCH. JAL/JALR go to WB.
  - MEM: mem_req = 1, mem_we = (SW). Hold until mem_ack. LW then goes to WB; SW does PC <= PC + 4 and goes to FETCH.
  - WB: RegWrite = 1 for exactly this cycle; MemtoReg = 1 only for LW; link = 1 only for JAL/JALR. Next PC is PC + IMM_J for JAL, (PCReg + IMM_I) & ~1 for JALR, and PC + 4 otherwise. Then go to FETCH.
  - TRAP: halted = 1; all strobes 0; no exit except reset.
- RD = x0: RegWrite is still pulsed. The datapath ignores RD = 0, so the controller does not gate it.
- ALUControl: 'b1000 for SUB and BEQ; 'b0000 for everything else. ALUSrc = 1 for ADDI/LW/SW/JALR.
- Arithmetic: all PC math is modulo 2^NBITS, so wrap-around is silent (e.g. PC = 'hFC + 4 gives 'h00). Immediates are sign-extended from their RV32I field and truncated to NBITS.
- Latency in cycles with zero-wait ack:
  - ADD/SUB/ADDI: 4 (F, D, E, W)
  - LW: 5
  - SW: 4
  - BEQ: 3
  - JAL/JALR: 4
- instr_ack or mem_ack asserted outside their owning state is ignored.
- Reset asserted mid-operation aborts immediately. Any in-flight req drops asynchronously, and no RegWrite is issued.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum: FETCH, DECODE, EXEC, MEM, WB, TRAP
  - opcode constants: OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111
  - ALU codes: ALU_ADD = 4'b0000, ALU_SUB = 4'b1000
- Sub-module instr_decoder: purely combinational IR to {RS1, RS2, RD, IMM, class, illegal}. The FSM plus PC register stay in multicycle_controller.

Test Plan:
- Reset with PC_RESET = 0; fetch 'addi x1,x0,5' with ack after 2 wait cycles -> instr_req held 3 cycles at addr 0; RS1 = 0, RD = 1, IMM = 5, ALUSrc = 1; RegWrite pulses once; next fetch addr = 4.
- 'sub x3,x1,x2' -> ALUControl = 'b1000, ALUSrc = 0, RegWrite one cycle in WB; total 4 cycles with zero-wait ack.
- 'beq x1,x1,-8' at PC = 'h10 with Zero = 1 -> next fetch addr 'h08. Same with Zero = 0 -> 'h14. RegWrite never asserted.
- 'lw x5,4(x0)' with mem_ack delayed 3 cycles -> mem_req = 1 and mem_we = 0 for 4 cycles; then MemtoReg = 1 and RegWrite = 1 in WB. 'sw' -> mem_we = 1, no RegWrite.
- 'jal x1,+8' at PC = 'hFC -> link = 1, pclink = 'h00 (wrap), next fetch 'h04. Then instr_rdata = 32'h0000_0000 -> halted = 1, instr_req stays 0 forever.
- Assert reset during MEM with mem_req = 1 -> mem_req drops in the same cycle (async). After release, PC = PC_RESET and the first instr_req occurs on the next clock.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg: states, instruction classes, opcodes and ALU codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_ADD     = 4'd0,
    CLS_SUB     = 4'd1,
    CLS_ADDI    = 4'd2,
    CLS_LW      = 4'd3,
    CLS_SW      = 4'd4,
    CLS_BEQ     = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_JALR    = 4'd7,
    CLS_ILLEGAL = 4'd8
  } iclass_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  function automatic logic uses_imm_srcb(input iclass_t c);
    return (c == CLS_ADDI) || (c == CLS_LW) || (c == CLS_SW) || (c == CLS_JALR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if: fetch port, data-memory handshake, datapath bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface multicycle_controller_if #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
);
  localparam int RW = $clog2(NREGS);

  logic                  instr_req;
  logic [NBITS-1:0]      instr_addr;
  logic                  instr_ack;
  logic [31:0]           instr_rdata;
  logic [RW-1:0]         RS1;
  logic [RW-1:0]         RS2;
  logic [RW-1:0]         RD;
  logic [NBITS-1:0]      IMM;
  logic [WIDTH_ALUF-1:0] ALUControl;
  logic                  ALUSrc;
  logic                  MemtoReg;
  logic                  RegWrite;
  logic                  link;
  logic [NBITS-1:0]      pclink;
  logic                  Zero;
  logic [NBITS-1:0]      PCReg;
  logic                  mem_req;
  logic                  mem_we;
  logic                  mem_ack;
  logic                  halted;

  modport master (
    output instr_req, instr_addr,
    input  instr_ack, instr_rdata,
    output RS1, RS2, RD, IMM, ALUControl, ALUSrc, MemtoReg, RegWrite, link, pclink,
    input  Zero, PCReg,
    output mem_req, mem_we,
    input  mem_ack,
    output halted
  );

  modport slave (
    input  instr_req, instr_addr,
    output instr_ack, instr_rdata,
    input  RS1, RS2, RD, IMM, ALUControl, ALUSrc, MemtoReg, RegWrite, link, pclink,
    output Zero, PCReg,
    input  mem_req, mem_we,
    output mem_ack,
    input  halted
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_controller_instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder: combinational IR -> register fields, immediate, class
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int RW    = 5
) (
  input  logic [31:0]      ir,
  output logic [RW-1:0]    rs1,
  output logic [RW-1:0]    rs2,
  output logic [RW-1:0]    rd,
  output logic [NBITS-1:0] imm,
  output iclass_t          iclass,
  output logic             illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign funct7  = ir[31:25];
  assign rs1     = RW'(ir[19:15]);
  assign rs2     = RW'(ir[24:20]);
  assign rd      = RW'(ir[11:7]);
  assign illegal = (iclass == CLS_ILLEGAL);

  always_comb begin
    iclass = CLS_ILLEGAL;
    case (opcode)
      OP_R: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) iclass = CLS_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) iclass = CLS_SUB;
      end
      OP_I:    if (funct3 == 3'b000) iclass = CLS_ADDI;
      OP_LW:   if (funct3 == 3'b010) iclass = CLS_LW;
      OP_SW:   if (funct3 == 3'b010) iclass = CLS_SW;
      OP_BEQ:  if (funct3 == 3'b000) iclass = CLS_BEQ;
      OP_JAL:  iclass = CLS_JAL;
      OP_JALR: if (funct3 == 3'b000) iclass = CLS_JALR;
      default: iclass = CLS_ILLEGAL;
    endcase
  end

  // Sign-extend to 32 bits in the RV32I layout, then keep the low NBITS.
  always_comb begin
    imm = '0;
    case (iclass)
      CLS_ADDI, CLS_LW, CLS_JALR:
        imm = NBITS'({{20{ir[31]}}, ir[31:20]});
      CLS_SW:
        imm = NBITS'({{20{ir[31]}}, ir[31:25], ir[11:7]});
      CLS_BEQ:
        imm = NBITS'({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
      CLS_JAL:
        imm = NBITS'({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
      default: imm = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller: PC, IR and FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int               NBITS      = 8,
  parameter int               NREGS      = 32,
  parameter int               WIDTH_ALUF = 4,
  parameter logic [NBITS-1:0] PC_RESET   = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  localparam int               RW   = $clog2(NREGS);
  localparam logic [NBITS-1:0] FOUR = NBITS'(4);

  state_t           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             started_q, started_d;

  logic [RW-1:0]    rs1, rs2, rd;
  logic [NBITS-1:0] imm;
  iclass_t          iclass;
  logic             illegal;
  logic [NBITS-1:0] pc_plus4;
  logic [NBITS-1:0] jalr_target;

  instr_decoder #(
    .NBITS (NBITS),
    .RW    (RW)
  ) u_decoder (
    .ir      (ir_q),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .imm     (imm),
    .iclass  (iclass),
    .illegal (illegal)
  );

  assign pc_plus4 = pc_q + FOUR;

  always_comb begin
    jalr_target    = bus.PCReg + imm;
    jalr_target[0] = 1'b0;
  end

  // started_q keeps instr_req low until the first clock after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    started_d = 1'b1;
    case (state_q)
      FETCH: begin
        if (started_q && bus.instr_ack) begin
          ir_d    = bus.instr_rdata;
          state_d = DECODE;
        end
      end
      DECODE: state_d = illegal ? TRAP : EXEC;
      EXEC: begin
        case (iclass)
          CLS_BEQ: begin
            pc_d    = bus.Zero ? (pc_q + imm) : pc_plus4;
            state_d = FETCH;
          end
          CLS_LW, CLS_SW: state_d = MEM;
          default:        state_d = WB;
        endcase
      end
      MEM: begin
        if (bus.mem_ack) begin
          if (iclass == CLS_SW) begin
            pc_d    = pc_plus4;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        case (iclass)
          CLS_JAL:  pc_d = pc_q + imm;
          CLS_JALR: pc_d = jalr_target;
          default:  pc_d = pc_plus4;
        endcase
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  assign bus.instr_req  = (state_q == FETCH) && started_q;
  assign bus.instr_addr = pc_q;
  assign bus.RS1        = rs1;
  assign bus.RS2        = rs2;
  assign bus.RD         = rd;
  assign bus.IMM        = imm;
  assign bus.ALUControl = ((iclass == CLS_SUB) || (iclass == CLS_BEQ)) ?
                          WIDTH_ALUF'(ALU_SUB) : WIDTH_ALUF'(ALU_ADD);
  assign bus.ALUSrc     = uses_imm_srcb(iclass);
  assign bus.MemtoReg   = (iclass == CLS_LW);
  assign bus.RegWrite   = (state_q == WB);
  assign bus.link       = (state_q == WB) && ((iclass == CLS_JAL) || (iclass == CLS_JALR));
  assign bus.pclink     = illegal ? '0 : pc_plus4;
  assign bus.mem_req    = (state_q == MEM);
  assign bus.mem_we     = (state_q == MEM) && (iclass == CLS_SW);
  assign bus.halted     = (state_q == TRAP);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller: directed program walk with immediate assertions
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_controller;
  import ctrl_pkg::*;

  localparam int NBITS      = 8;
  localparam int NREGS      = 32;
  localparam int WIDTH_ALUF = 4;

  localparam logic [31:0] I_ADDI = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_SUB  = 32'h4020_81B3; // sub  x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0040_2283; // lw   x5,4(x0)
  localparam logic [31:0] I_SW   = 32'h0050_2423; // sw   x5,8(x0)
  localparam logic [31:0] I_BEQ  = 32'hFE10_8CE3; // beq  x1,x1,-8
  localparam logic [31:0] I_JALR = 32'h0001_0067; // jalr x0,0(x2)
  localparam logic [31:0] I_JAL  = 32'h0080_00EF; // jal  x1,+8

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   req_cycles;

  multicycle_controller_if #(
    .NBITS      (NBITS),
    .NREGS      (NREGS),
    .WIDTH_ALUF (WIDTH_ALUF)
  ) bus ();

  multicycle_controller #(
    .NBITS      (NBITS),
    .NREGS      (NREGS),
    .WIDTH_ALUF (WIDTH_ALUF),
    .PC_RESET   (8'h00)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] instr, input logic [31:0] addr);
    chk({tag, "_req"}, 32'(bus.instr_req), 32'd1);
    chk({tag, "_addr"}, 32'(bus.instr_addr), addr);
    bus.instr_ack   = 1'b1;
    bus.instr_rdata = instr;
    step();
    bus.instr_ack   = 1'b0;
    bus.instr_rdata = 32'h0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    req_cycles      = 0;
    bus.instr_ack   = 1'b0;
    bus.instr_rdata = 32'h0;
    bus.Zero        = 1'b0;
    bus.PCReg       = 8'h00;
    bus.mem_ack     = 1'b0;
    reset           = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_req",      32'(bus.instr_req),  0);
    chk("rst_regwrite", 32'(bus.RegWrite),   0);
    chk("rst_link",     32'(bus.link),       0);
    chk("rst_memreq",   32'(bus.mem_req),    0);
    chk("rst_memwe",    32'(bus.mem_we),     0);
    chk("rst_halted",   32'(bus.halted),     0);
    chk("rst_rs1",      32'(bus.RS1),        0);
    chk("rst_rd",       32'(bus.RD),         0);
    chk("rst_imm",      32'(bus.IMM),        0);
    chk("rst_aluctl",   32'(bus.ALUControl), 0);
    chk("rst_alusrc",   32'(bus.ALUSrc),     0);
    chk("rst_memtoreg", 32'(bus.MemtoReg),   0);
    chk("rst_pclink",   32'(bus.pclink),     0);
    chk("rst_addr",     32'(bus.instr_addr), 0);

    // Release away from the edge; first request only after the next clock.
    step();
    reset = 1'b1;
    chk("rel_req_low", 32'(bus.instr_req), 0);
    step();

    // addi x1,x0,5 with two wait cycles on the fetch ack.
    for (int i = 0; i < 3; i++) begin
      if (bus.instr_req) req_cycles++;
      chk("addi_addr", 32'(bus.instr_addr), 0);
      if (i < 2) step();
    end
    chk("addi_req_cycles", 32'(req_cycles), 3);
    fetch("addi_f", I_ADDI, 32'h00);
    chk("addi_dec_req", 32'(bus.instr_req), 0);
    chk("addi_rs1",     32'(bus.RS1),       0);
    chk("addi_rd",      32'(bus.RD),        1);
    chk("addi_imm",     32'(bus.IMM),       5);
    chk("addi_alusrc",  32'(bus.ALUSrc),    1);
    chk("addi_rw_d",    32'(bus.RegWrite),  0);
    step();
    chk("addi_rw_e",    32'(bus.RegWrite),  0);
    step();
    chk("addi_rw_w",    32'(bus.RegWrite),  1);
    step();
    chk("addi_rw_f",    32'(bus.RegWrite),  0);

    // sub x3,x1,x2: four cycles, ack in the fetch cycle.
    fetch("sub_f", I_SUB, 32'h04);
    chk("sub_aluctl", 32'(bus.ALUControl), 32'h8);
    chk("sub_alusrc", 32'(bus.ALUSrc),     0);
    chk("sub_rs1",    32'(bus.RS1),        1);
    chk("sub_rs2",    32'(bus.RS2),        2);
    chk("sub_rd",     32'(bus.RD),         3);
    step();
    chk("sub_rw_e",   32'(bus.RegWrite),   0);
    step();
    chk("sub_rw_w",   32'(bus.RegWrite),   1);
    step();
    chk("sub_rw_f",   32'(bus.RegWrite),   0);

    // lw x5,4(x0) with mem_ack after three wait cycles.
    fetch("lw_f", I_LW, 32'h08);
    chk("lw_rd",     32'(bus.RD),     5);
    chk("lw_imm",    32'(bus.IMM),    4);
    chk("lw_alusrc", 32'(bus.ALUSrc), 1);
    step();
    chk("lw_memreq_e", 32'(bus.mem_req), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("lw_memreq",   32'(bus.mem_req),  1);
      chk("lw_memwe",    32'(bus.mem_we),   0);
      chk("lw_rw_mem",   32'(bus.RegWrite), 0);
      if (i == 3) bus.mem_ack = 1'b1;
      step();
    end
    bus.mem_ack = 1'b0;
    chk("lw_memreq_w",  32'(bus.mem_req),  0);
    chk("lw_rw_w",      32'(bus.RegWrite), 1);
    chk("lw_memtoreg",  32'(bus.MemtoReg), 1);
    step();

    // sw x5,8(x0): store, no write-back.
    fetch("sw_f", I_SW, 32'h0C);
    chk("sw_imm",  32'(bus.IMM), 8);
    chk("sw_rs2",  32'(bus.RS2), 5);
    chk("sw_rw_d", 32'(bus.RegWrite), 0);
    step();
    chk("sw_rw_e", 32'(bus.RegWrite), 0);
    step();
    chk("sw_memreq", 32'(bus.mem_req),  1);
    chk("sw_memwe",  32'(bus.mem_we),   1);
    chk("sw_rw_m",   32'(bus.RegWrite), 0);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("sw_rw_f",   32'(bus.RegWrite), 0);

    // beq x1,x1,-8 at 0x10, taken.
    fetch("beq1_f", I_BEQ, 32'h10);
    chk("beq_imm",    32'(bus.IMM),        32'hF8);
    chk("beq_aluctl", 32'(bus.ALUControl), 32'h8);
    bus.Zero = 1'b1;
    step();
    chk("beq1_rw_e", 32'(bus.RegWrite), 0);
    step();
    bus.Zero = 1'b0;
    chk("beq1_rw_f", 32'(bus.RegWrite), 0);

    // sub then sw bring the PC back to 0x10 for the not-taken branch.
    fetch("sub2_f", I_SUB, 32'h08);
    step();
    step();
    step();
    fetch("sw2_f", I_SW, 32'h0C);
    step();
    step();
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    fetch("beq2_f", I_BEQ, 32'h10);
    step();
    chk("beq2_rw_e", 32'(bus.RegWrite), 0);
    step();

    // jalr x0,0(x2) with an odd base: bit 0 of the target is cleared.
    bus.PCReg = 8'hFD;
    fetch("jalr_f", I_JALR, 32'h14);
    chk("jalr_alusrc", 32'(bus.ALUSrc), 1);
    chk("jalr_rs1",    32'(bus.RS1),    2);
    step();
    step();
    chk("jalr_link",   32'(bus.link),     1);
    chk("jalr_rw",     32'(bus.RegWrite), 1);
    chk("jalr_pclink", 32'(bus.pclink),   32'h18);
    step();

    // jal x1,+8 at 0xFC: PC+4 and target both wrap.
    fetch("jal_f", I_JAL, 32'hFC);
    chk("jal_imm",    32'(bus.IMM),    8);
    chk("jal_pclink", 32'(bus.pclink), 32'h00);
    step();
    chk("jal_link_e", 32'(bus.link),   0);
    step();
    chk("jal_link_w", 32'(bus.link),     1);
    chk("jal_rw_w",   32'(bus.RegWrite), 1);
    step();

    // All-zero word is illegal: trap, and stay there despite stray acks.
    fetch("ill_f", 32'h0000_0000, 32'h04);
    chk("ill_halted_d", 32'(bus.halted), 0);
    step();
    bus.instr_ack = 1'b1;
    bus.mem_ack   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("trap_halted", 32'(bus.halted),    1);
      chk("trap_req",    32'(bus.instr_req), 0);
      chk("trap_rw",     32'(bus.RegWrite),  0);
      chk("trap_memreq", 32'(bus.mem_req),   0);
      step();
    end
    bus.instr_ack = 1'b0;
    bus.mem_ack   = 1'b0;

    // Reset out of TRAP, run to MEM of a load, then abort asynchronously.
    reset = 1'b0;
    #1;
    chk("trap_rst_halted", 32'(bus.halted), 0);
    step();
    reset = 1'b1;
    step();
    fetch("lw2_f", I_LW, 32'h00);
    step();
    step();
    chk("lw2_memreq", 32'(bus.mem_req), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_memreq", 32'(bus.mem_req),   0);
    chk("abort_req",    32'(bus.instr_req), 0);
    chk("abort_rw",     32'(bus.RegWrite),  0);
    step();
    chk("abort_rw_hold", 32'(bus.RegWrite), 0);
    reset = 1'b1;
    chk("rel2_addr",    32'(bus.instr_addr), 0);
    chk("rel2_req_low", 32'(bus.instr_req),  0);
    step();
    chk("rel2_req",      32'(bus.instr_req),  1);
    chk("rel2_req_addr", 32'(bus.instr_addr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
